// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, constants and helpers for the LUT-based Ascon permutation
package ascon_pkg;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_e;

    localparam logic [3:0] ROUNDS_MAX = 4'd12;

    // Standard Ascon S-box, index = {x0,x1,x2,x3,x4} column bits with x0 as MSB
    localparam logic [4:0] SBOX_RST [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic nrounds_legal(input logic [3:0] n, input int urol);
        logic ok;
        ok = (n == 4'd6) || (n == 4'd8) || (n == 4'd12);
        return ok && ((int'(n) % urol) == 0);
    endfunction

endpackage

// File: rtl/asconp_lut.sv
// rtl/asconp_lut.sv - UROL unrolled Ascon rounds with a runtime-writable S-box table
module asconp_lut
    import ascon_pkg::*;
#(
    parameter int UROL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   round_i,
    input  ascon_state_t x_i,
    output ascon_state_t x_o,
    input  logic         upd_sbox,
    input  logic [4:0]   upd_addr,
    input  logic [19:0]  upd_data
);

    logic [31:0][4:0] sbox_q;
    ascon_state_t     st;

    // Only the low five bits of an entry carry the S-box output
    logic unused_upd_hi;
    assign unused_upd_hi = ^upd_data[19:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                sbox_q[i] <= SBOX_RST[i];
            end
        end else if (upd_sbox) begin
            sbox_q[upd_addr] <= upd_data[4:0];
        end
    end

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic ascon_state_t round_f(input ascon_state_t s_in, input logic [3:0] r,
                                             input logic [31:0][4:0] tbl);
        ascon_state_t s;
        ascon_state_t t;
        ascon_state_t y;
        logic [4:0]   col;
        logic [4:0]   o;
        s = s_in;
        t = '0;
        s.x2[7:0] = s.x2[7:0] ^ {~r, r};
        for (int j = 0; j < 64; j++) begin
            col     = {s.x0[j], s.x1[j], s.x2[j], s.x3[j], s.x4[j]};
            o       = tbl[col];
            t.x0[j] = o[4];
            t.x1[j] = o[3];
            t.x2[j] = o[2];
            t.x3[j] = o[1];
            t.x4[j] = o[0];
        end
        y.x0 = t.x0 ^ ror64(t.x0, 19) ^ ror64(t.x0, 28);
        y.x1 = t.x1 ^ ror64(t.x1, 61) ^ ror64(t.x1, 39);
        y.x2 = t.x2 ^ ror64(t.x2, 1)  ^ ror64(t.x2, 6);
        y.x3 = t.x3 ^ ror64(t.x3, 10) ^ ror64(t.x3, 17);
        y.x4 = t.x4 ^ ror64(t.x4, 7)  ^ ror64(t.x4, 41);
        return y;
    endfunction

    always_comb begin
        st = x_i;
        for (int k = 0; k < UROL; k++) begin
            st = round_f(st, round_i + 4'(k), sbox_q);
        end
        x_o = st;
    end

endmodule

// File: rtl/asconp_lut_ctrl.sv
// rtl/asconp_lut_ctrl.sv - job/config sequencer and state holder around asconp_lut
module asconp_lut_ctrl
    import ascon_pkg::*;
#(
    parameter int UROL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid_i,
    output logic        start_ready_o,
    input  logic [3:0]  nrounds_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        done_valid_o,
    input  logic        done_ready_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        err_o,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [4:0]  cfg_addr_i,
    input  logic [19:0] cfg_data_i,
    output logic        busy_o
);

    ctrl_state_e  state_q, state_d;
    ascon_state_t st_q;
    ascon_state_t lut_out;
    logic [3:0]   round_cnt_q;
    logic [4:0]   cfg_addr_q;
    logic [19:0]  cfg_data_q;
    logic         err_q;
    logic         rst_n;
    logic         cfg_fire, start_fire, job_legal, run_last, in_done;

    assign rst_n = ~rst;

    // Config writes win over jobs so a permutation never sees a half-updated table
    assign cfg_ready_o   = (state_q == IDLE) && !rst;
    assign start_ready_o = (state_q == IDLE) && !rst && !cfg_valid_i;
    assign cfg_fire      = cfg_valid_i && cfg_ready_o;
    assign start_fire    = start_valid_i && start_ready_o;
    assign job_legal     = nrounds_legal(nrounds_i, UROL);
    assign run_last      = ({1'b0, round_cnt_q} + 5'(UROL)) == {1'b0, ROUNDS_MAX};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    state_d = CFG;
                end else if (start_fire && job_legal) begin
                    state_d = RUN;
                end
            end
            CFG:     state_d = IDLE;
            RUN:     if (run_last) state_d = DONE;
            DONE:    if (done_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= '0;
            round_cnt_q <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= start_fire && !job_legal;
            if (cfg_fire) begin
                cfg_addr_q <= cfg_addr_i;
                cfg_data_q <= cfg_data_i;
            end
            if (start_fire && job_legal) begin
                st_q        <= '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
                round_cnt_q <= ROUNDS_MAX - nrounds_i;
            end else if (state_q == RUN) begin
                st_q        <= lut_out;
                round_cnt_q <= round_cnt_q + 4'(UROL);
            end
        end
    end

    asconp_lut #(
        .UROL(UROL)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .round_i  (round_cnt_q),
        .x_i      (st_q),
        .x_o      (lut_out),
        .upd_sbox (state_q == CFG),
        .upd_addr (cfg_addr_q),
        .upd_data (cfg_data_q)
    );

    assign in_done      = (state_q == DONE);
    assign done_valid_o = in_done;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign x0_o         = in_done ? st_q.x0 : '0;
    assign x1_o         = in_done ? st_q.x1 : '0;
    assign x2_o         = in_done ? st_q.x2 : '0;
    assign x3_o         = in_done ? st_q.x3 : '0;
    assign x4_o         = in_done ? st_q.x4 : '0;

endmodule

// File: tb/tb_asconp_lut_ctrl.sv
// tb/tb_asconp_lut_ctrl.sv - self-checking bench for asconp_lut_ctrl at UROL 1, 2 and 4
module tb_asconp_lut_ctrl;

    typedef logic [4:0][63:0] st_t;
    typedef struct { int inst; int n; int lat; } vec_t;

    localparam logic [4:0] SBOX[32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        start_valid[3], start_ready[3], done_valid[3], done_ready[3];
    logic        err[3], cfg_valid[3], cfg_ready[3], busy[3];
    logic [3:0]  nrounds[3];
    logic [4:0]  cfg_addr[3];
    logic [19:0] cfg_data[3];
    logic [63:0] xi[3][5];
    logic [63:0] xo[3][5];
    logic [4:0]  tbl[3][32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        asconp_lut_ctrl #(.UROL((g == 0) ? 1 : ((g == 1) ? 2 : 4))) dut (
            .clk(clk), .rst(rst),
            .start_valid_i(start_valid[g]), .start_ready_o(start_ready[g]),
            .nrounds_i(nrounds[g]),
            .x0_i(xi[g][0]), .x1_i(xi[g][1]), .x2_i(xi[g][2]), .x3_i(xi[g][3]), .x4_i(xi[g][4]),
            .done_valid_o(done_valid[g]), .done_ready_i(done_ready[g]),
            .x0_o(xo[g][0]), .x1_o(xo[g][1]), .x2_o(xo[g][2]), .x3_o(xo[g][3]), .x4_o(xo[g][4]),
            .err_o(err[g]),
            .cfg_valid_i(cfg_valid[g]), .cfg_ready_o(cfg_ready[g]),
            .cfg_addr_i(cfg_addr[g]), .cfg_data_i(cfg_data[g]),
            .busy_o(busy[g])
        );
    end

    function automatic int urol_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference: the last n of the 12 Ascon rounds, using the instance's current S-box table
    function automatic st_t model_perm(input int inst, input int n, input st_t s_in);
        st_t s, t;
        logic [3:0] rr;
        logic [4:0] col, o;
        s = s_in;
        for (int r = 12 - n; r < 12; r++) begin
            rr = r[3:0];
            s[2][7:0] = s[2][7:0] ^ {~rr, rr};
            for (int j = 0; j < 64; j++) begin
                col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
                o = tbl[inst][col];
                t[0][j] = o[4]; t[1][j] = o[3]; t[2][j] = o[2]; t[3][j] = o[1]; t[4][j] = o[0];
            end
            s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
            s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
            s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
            s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
            s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        end
        return s;
    endfunction

    function automatic st_t rand_st();
        st_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic st_t get_out(input int i);
        st_t s;
        for (int k = 0; k < 5; k++) s[k] = xo[i][k];
        return s;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 32; a++) tbl[i][a] = SBOX[a];
    endtask

    task automatic set_x(input int i, input st_t s);
        for (int k = 0; k < 5; k++) xi[i][k] = s[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chks(input string name, input st_t act, input st_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // exp_lat == 0 means the job must be rejected with an err pulse
    task automatic run_job(input int inst, input int n, input st_t x, input int exp_lat, input int hold);
        st_t exp;
        int  cyc;
        exp = (exp_lat > 0) ? model_perm(inst, n, x) : x;
        set_x(inst, x);
        nrounds[inst] = n[3:0];
        start_valid[inst] = 1'b1;
        #1;
        cyc = 0;
        while (!start_ready[inst] && cyc < 50) begin
            tick();
            cyc++;
        end
        chk1("start_ready_wait", start_ready[inst], 1'b1);
        tick();
        start_valid[inst] = 1'b0;
        set_x(inst, rand_st());
        if (exp_lat == 0) begin
            chk1("err_pulse", err[inst], 1'b1);
            chk1("err_no_run", busy[inst], 1'b0);
            tick();
            chk1("err_one_cycle", err[inst], 1'b0);
            chk1("err_still_idle", busy[inst], 1'b0);
            return;
        end
        chk1("no_err_legal", err[inst], 1'b0);
        cyc = 0;
        while (!done_valid[inst] && cyc < 40) begin
            tick();
            cyc++;
        end
        chki($sformatf("latency_u%0d_p%0d", urol_of(inst), n), cyc, exp_lat);
        chks($sformatf("result_u%0d_p%0d", urol_of(inst), n), get_out(inst), exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk1("done_held", done_valid[inst], 1'b1);
            chks("result_stable", get_out(inst), exp);
        end
        chk1("no_accept_in_done", start_ready[inst], 1'b0);
        done_ready[inst] = 1'b1;
        tick();
        done_ready[inst] = 1'b0;
        chk1("done_dropped", done_valid[inst], 1'b0);
        chk1("idle_after_done", busy[inst], 1'b0);
    endtask

    initial begin
        vec_t vecs[$];
        st_t  x, exp;
        int   cyc, n, inst, u;
        logic flag;

        for (int i = 0; i < 3; i++) begin
            start_valid[i] = 0; done_ready[i] = 0; cfg_valid[i] = 0;
            nrounds[i] = 0; cfg_addr[i] = 0; cfg_data[i] = 0;
            for (int k = 0; k < 5; k++) xi[i][k] = 0;
        end
        reset_model();

        // reset state
        #12;
        for (int i = 0; i < 3; i++) begin
            chk1("rst_start_ready", start_ready[i], 1'b0);
            chk1("rst_cfg_ready", cfg_ready[i], 1'b0);
            chk1("rst_busy", busy[i], 1'b0);
        end
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk1("post_rst_start_ready", start_ready[i], 1'b1);
            chk1("post_rst_cfg_ready", cfg_ready[i], 1'b1);
            chk1("post_rst_done", done_valid[i], 1'b0);
            chk1("post_rst_err", err[i], 1'b0);
            chks("post_rst_out", get_out(i), '0);
        end

        // p12 on zero state, result held for 5 cycles
        run_job(0, 12, '0, 12, 5);

        vecs.push_back('{0, 12, 12}); vecs.push_back('{0, 6, 6});  vecs.push_back('{0, 8, 8});
        vecs.push_back('{0, 7, 0});   vecs.push_back('{1, 6, 3});  vecs.push_back('{1, 8, 4});
        vecs.push_back('{1, 12, 6});  vecs.push_back('{1, 7, 0});  vecs.push_back('{2, 8, 2});
        vecs.push_back('{2, 12, 3});  vecs.push_back('{2, 6, 0});  vecs.push_back('{0, 0, 0});
        vecs.push_back('{2, 15, 0});
        foreach (vecs[v]) run_job(vecs[v].inst, vecs[v].n, rand_st(), vecs[v].lat, $urandom_range(0, 2));

        for (int k = 0; k < 6; k++) begin
            inst = $urandom_range(0, 2);
            u = urol_of(inst);
            case ($urandom_range(0, 2))
                0: n = 6;
                1: n = 8;
                default: n = 12;
            endcase
            run_job(inst, n, rand_st(), (n % u == 0) ? n / u : 0, 0);
        end

        // simultaneous cfg and job: cfg wins, job then sees the new entry
        x = rand_st();
        set_x(1, x);
        nrounds[1] = 4'd12;
        start_valid[1] = 1'b1;
        cfg_valid[1] = 1'b1;
        cfg_addr[1] = 5'd0;
        cfg_data[1] = 20'hABC00;
        #1;
        chk1("simul_start_blocked", start_ready[1], 1'b0);
        chk1("simul_cfg_ready", cfg_ready[1], 1'b1);
        tick();
        cfg_valid[1] = 1'b0;
        #1;
        chk1("simul_in_cfg_busy", busy[1], 1'b1);
        chk1("simul_in_cfg_no_start", start_ready[1], 1'b0);
        tbl[1][0] = 5'h00;
        run_job(1, 12, x, 6, 0);

        // cfg held during RUN is not accepted until the job has been handed off
        x = rand_st();
        exp = model_perm(0, 8, x);
        set_x(0, x);
        nrounds[0] = 4'd8;
        start_valid[0] = 1'b1;
        #1;
        tick();
        start_valid[0] = 1'b0;
        cfg_valid[0] = 1'b1;
        cfg_addr[0] = 5'd3;
        cfg_data[0] = 20'h0001F;
        flag = 1'b0;
        cyc = 0;
        #1;
        while (!done_valid[0] && cyc < 40) begin
            if (cfg_ready[0]) flag = 1'b1;
            tick();
            cyc++;
        end
        chk1("cfg_blocked_in_run", flag, 1'b0);
        chki("cfg_run_latency", cyc, 8);
        chks("cfg_run_result_unaffected", get_out(0), exp);
        chk1("cfg_blocked_in_done", cfg_ready[0], 1'b0);
        done_ready[0] = 1'b1;
        tick();
        done_ready[0] = 1'b0;
        chk1("cfg_ready_after_done", cfg_ready[0], 1'b1);
        tick();
        cfg_valid[0] = 1'b0;
        chk1("cfg_write_cycle", busy[0], 1'b1);
        tbl[0][3] = 5'h1F;
        tick();
        chk1("cfg_back_idle", busy[0], 1'b0);
        run_job(0, 12, rand_st(), 12, 0);

        // async reset at RUN cycle 5 aborts the job without done or err
        set_x(0, rand_st());
        nrounds[0] = 4'd12;
        start_valid[0] = 1'b1;
        #1;
        tick();
        start_valid[0] = 1'b0;
        repeat (5) tick();
        chk1("pre_abort_busy", busy[0], 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk1("abort_busy", busy[0], 1'b0);
        chk1("abort_done", done_valid[0], 1'b0);
        chk1("abort_err", err[0], 1'b0);
        chk1("abort_start_ready", start_ready[0], 1'b0);
        chk1("abort_cfg_ready", cfg_ready[0], 1'b0);
        chks("abort_out", get_out(0), '0);
        tick();
        #3;
        rst = 1'b0;
        reset_model();
        flag = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done_valid[0] || err[0] || busy[0]) flag = 1'b1;
        end
        chk1("no_done_after_abort", flag, 1'b0);
        chk1("ready_after_abort", start_ready[0], 1'b1);
        run_job(0, 12, rand_st(), 12, 0);
        run_job(1, 12, rand_st(), 6, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
